// File: rtl/dram_arbiter_pkg.sv
// Shared GPU memory-interconnect types: master ids, arbiter state and read-return tags.
package gpu_mem_pkg;

   localparam int GPU_NUM_MASTERS = 3;
   localparam int MID_W           = (GPU_NUM_MASTERS > 1) ? $clog2(GPU_NUM_MASTERS) : 1;

   typedef logic [MID_W-1:0] mid_t;

   localparam mid_t MID_VERTEX_FETCH = 2'd0;
   localparam mid_t MID_SHADER       = 2'd1;
   localparam mid_t MID_FRAMEBUFFER  = 2'd2;

   typedef enum logic [0:0] {
      ARB_IDLE   = 1'b0,
      ARB_LOCKED = 1'b1
   } arb_state_t;

   typedef struct packed {
      logic valid;
      mid_t mid;
   } rd_tag_t;

   function automatic mid_t next_mid(input mid_t m);
      mid_t r;
      if (m == mid_t'(GPU_NUM_MASTERS - 1)) begin
         r = '0;
      end else begin
         r = m + mid_t'(1'b1);
      end
      return r;
   endfunction

   function automatic mid_t oh_to_mid(input logic [GPU_NUM_MASTERS-1:0] oh);
      mid_t m;
      m = '0;
      for (int i = 0; i < GPU_NUM_MASTERS; i++) begin
         if (oh[i]) begin
            m = mid_t'(i);
         end else begin
            m = m;
         end
      end
      return m;
   endfunction

endpackage

// File: rtl/dram_arbiter_if.sv
// Master-side request/return bus plus the shared DRAM pins of the arbiter.
interface dram_arbiter_if #(
   parameter int NUM_MASTERS = 3,
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 32
);

   logic [NUM_MASTERS-1:0]                 i_req;
   logic [NUM_MASTERS-1:0]                 i_we;
   logic [NUM_MASTERS-1:0]                 i_lock;
   logic [NUM_MASTERS-1:0][ADDR_WIDTH-1:0] i_addr;
   logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0] i_wdata;
   logic [NUM_MASTERS-1:0]                 o_gnt;
   logic [NUM_MASTERS-1:0]                 o_rvalid;
   logic [DATA_WIDTH-1:0]                  o_rdata;
   logic                                   o_dram_req;
   logic                                   o_dram_we;
   logic [ADDR_WIDTH-1:0]                  o_dram_addr;
   logic [DATA_WIDTH-1:0]                  o_dram_wdata;
   logic [DATA_WIDTH-1:0]                  i_dram_rdata;

   modport slave (
      input  i_req, i_we, i_lock, i_addr, i_wdata, i_dram_rdata,
      output o_gnt, o_rvalid, o_rdata,
      output o_dram_req, o_dram_we, o_dram_addr, o_dram_wdata
   );

   modport master (
      output i_req, i_we, i_lock, i_addr, i_wdata, i_dram_rdata,
      input  o_gnt, o_rvalid, o_rdata,
      input  o_dram_req, o_dram_we, o_dram_addr, o_dram_wdata
   );

endinterface

// File: rtl/dram_arbiter_rr.sv
// Combinational round-robin picker: first requester at or after the pointer, wrapping.
module rr_arbiter #(
   parameter int NUM_MASTERS = 3,
   parameter int PTR_W       = 2
) (
   input  logic [NUM_MASTERS-1:0] req_i,
   input  logic [PTR_W-1:0]       ptr_i,
   output logic [NUM_MASTERS-1:0] gnt_o
);

   localparam int SW = PTR_W + 1;

   logic [SW-1:0] idx_s;
   logic          found_s;

   // Scan once around the ring starting at the pointer; first hit wins.
   always_comb begin
      gnt_o   = '0;
      found_s = 1'b0;
      idx_s   = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         idx_s = {1'b0, ptr_i} + SW'(i);
         if (idx_s >= SW'(NUM_MASTERS)) begin
            idx_s = idx_s - SW'(NUM_MASTERS);
         end else begin
            idx_s = idx_s;
         end
         if (!found_s && req_i[idx_s[PTR_W-1:0]]) begin
            gnt_o[idx_s[PTR_W-1:0]] = 1'b1;
            found_s                 = 1'b1;
         end else begin
            found_s = found_s;
         end
      end
   end

endmodule

// File: rtl/dram_arbiter.sv
// DRAM port arbiter for the GPU memory masters: round-robin with burst lock, tagged reads.
// Optional lock timeout is built when DRAM_ARB_LOCK_TIMEOUT_EN is defined.
module dram_arbiter
   import gpu_mem_pkg::*;
#(
   parameter int NUM_MASTERS = GPU_NUM_MASTERS,
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 32,
   parameter int RD_LATENCY  = 2,
   parameter int MAX_LOCK    = 16
) (
   input logic          clk,
   input logic          glbl_rst_n,
   dram_arbiter_if.slave bus
);

   if (RD_LATENCY < 1 || RD_LATENCY > 8 || MAX_LOCK < 2 ||
       NUM_MASTERS != GPU_NUM_MASTERS) begin : g_param_check
      $error("dram_arbiter: unsupported parameter set");
   end

   arb_state_t             state_q, state_d;
   mid_t                   ptr_q, ptr_d;
   mid_t                   owner_q, owner_d;
   logic [NUM_MASTERS-1:0] owner_oh_s;
   logic [NUM_MASTERS-1:0] arb_req_s;
   logic [NUM_MASTERS-1:0] rr_gnt_s;
   logic [NUM_MASTERS-1:0] o_gnt_s;
   logic                   owner_hold_s;
   logic                   any_gnt_s;
   logic                   lock_ok_s;
   logic                   timeout_hit_s;
   mid_t                   gnt_idx_s;

   logic                   dram_req_q;
   logic                   dram_we_q;
   logic [ADDR_WIDTH-1:0]  dram_addr_q;
   logic [DATA_WIDTH-1:0]  dram_wdata_q;

   rd_tag_t                tag_q [RD_LATENCY+1];
   rd_tag_t                tag_push_s;
   logic [NUM_MASTERS-1:0] rvalid_q;
   logic [DATA_WIDTH-1:0]  rdata_q;

   assign owner_oh_s   = NUM_MASTERS'(1'b1) << owner_q;
   assign owner_hold_s = (state_q == ARB_LOCKED) && bus.i_req[owner_q];
   // While the owner still requests, nobody else is visible to the picker.
   assign arb_req_s    = owner_hold_s ? owner_oh_s : bus.i_req;

   rr_arbiter #(
      .NUM_MASTERS (NUM_MASTERS),
      .PTR_W       (MID_W)
   ) u_rr (
      .req_i (arb_req_s),
      .ptr_i (ptr_q),
      .gnt_o (rr_gnt_s)
   );

   assign any_gnt_s = |rr_gnt_s;
   assign gnt_idx_s = oh_to_mid(rr_gnt_s);

`ifdef DRAM_ARB_LOCK_TIMEOUT_EN
   localparam int CNT_W = $clog2(MAX_LOCK + 1);

   logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
   logic             relock_blk_q, relock_blk_d;
   logic             others_req_s;

   assign timeout_hit_s = (lock_cnt_q == CNT_W'(MAX_LOCK - 1));
   assign others_req_s  = |(bus.i_req & ~owner_oh_s);
   assign lock_ok_s     = bus.i_lock[gnt_idx_s] &&
                          !(relock_blk_q && (gnt_idx_s == owner_q));

   // Locked-grant count and the re-lock block applied after a forced release.
   always_comb begin
      if (owner_hold_s) begin
         lock_cnt_d = lock_cnt_q + CNT_W'(1'b1);
      end else if (state_d == ARB_LOCKED) begin
         lock_cnt_d = CNT_W'(1'b1);
      end else begin
         lock_cnt_d = '0;
      end
      if (owner_hold_s && timeout_hit_s) begin
         relock_blk_d = 1'b1;
      end else if ((any_gnt_s && (gnt_idx_s != owner_q)) || !others_req_s) begin
         relock_blk_d = 1'b0;
      end else begin
         relock_blk_d = relock_blk_q;
      end
   end

   // Timeout bookkeeping registers.
   always_ff @(posedge clk or negedge glbl_rst_n) begin
      if (!glbl_rst_n) begin
         lock_cnt_q   <= '0;
         relock_blk_q <= 1'b0;
      end else begin
         lock_cnt_q   <= lock_cnt_d;
         relock_blk_q <= relock_blk_d;
      end
   end
`else
   assign timeout_hit_s = 1'b0;
   assign lock_ok_s     = bus.i_lock[gnt_idx_s];
`endif

   // Arbitration state: FSM state, round-robin pointer, lock owner.
   always_ff @(posedge clk or negedge glbl_rst_n) begin
      if (!glbl_rst_n) begin
         state_q <= ARB_IDLE;
         ptr_q   <= '0;
         owner_q <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         owner_q <= owner_d;
      end
   end

   // Next state: a holding owner keeps the port, otherwise a fresh round-robin pick.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      owner_d = owner_q;
      case (state_q)
         ARB_IDLE, ARB_LOCKED: begin
            if (owner_hold_s) begin
               if (bus.i_lock[owner_q] && !timeout_hit_s) begin
                  state_d = ARB_LOCKED;
               end else begin
                  state_d = ARB_IDLE;
               end
            end else if (any_gnt_s) begin
               ptr_d = next_mid(gnt_idx_s);
               if (lock_ok_s) begin
                  state_d = ARB_LOCKED;
                  owner_d = gnt_idx_s;
               end else begin
                  state_d = ARB_IDLE;
               end
            end else begin
               state_d = ARB_IDLE;
            end
         end
         default: begin
            state_d = ARB_IDLE;
         end
      endcase
   end

   // Grant output, forced low while reset is asserted.
   always_comb begin
      if (glbl_rst_n) begin
         o_gnt_s = rr_gnt_s;
      end else begin
         o_gnt_s = '0;
      end
   end

   // DRAM command: strobe every cycle, payload captured only on a grant.
   always_ff @(posedge clk or negedge glbl_rst_n) begin
      if (!glbl_rst_n) begin
         dram_req_q   <= 1'b0;
         dram_we_q    <= 1'b0;
         dram_addr_q  <= '0;
         dram_wdata_q <= '0;
      end else begin
         dram_req_q <= any_gnt_s;
         if (any_gnt_s) begin
            dram_we_q    <= bus.i_we[gnt_idx_s];
            dram_addr_q  <= bus.i_addr[gnt_idx_s];
            dram_wdata_q <= bus.i_wdata[gnt_idx_s];
         end else begin
            dram_we_q    <= dram_we_q;
            dram_addr_q  <= dram_addr_q;
            dram_wdata_q <= dram_wdata_q;
         end
      end
   end

   // Tag entering the read pipeline this cycle.
   always_comb begin
      tag_push_s.valid = any_gnt_s && !bus.i_we[gnt_idx_s];
      tag_push_s.mid   = gnt_idx_s;
   end

   // Read tag shift register; the last stage lines up with valid DRAM data.
   always_ff @(posedge clk or negedge glbl_rst_n) begin
      if (!glbl_rst_n) begin
         for (int k = 0; k <= RD_LATENCY; k++) begin
            tag_q[k] <= '0;
         end
      end else begin
         tag_q[0] <= tag_push_s;
         for (int k = 1; k <= RD_LATENCY; k++) begin
            tag_q[k] <= tag_q[k-1];
         end
      end
   end

   // Read return: one-cycle o_rvalid pulse to the tagged master.
   always_ff @(posedge clk or negedge glbl_rst_n) begin
      if (!glbl_rst_n) begin
         rvalid_q <= '0;
         rdata_q  <= '0;
      end else begin
         if (tag_q[RD_LATENCY].valid) begin
            rvalid_q <= NUM_MASTERS'(1'b1) << tag_q[RD_LATENCY].mid;
            rdata_q  <= bus.i_dram_rdata;
         end else begin
            rvalid_q <= '0;
            rdata_q  <= rdata_q;
         end
      end
   end

   assign bus.o_gnt        = o_gnt_s;
   assign bus.o_rvalid     = rvalid_q;
   assign bus.o_rdata      = rdata_q;
   assign bus.o_dram_req   = dram_req_q;
   assign bus.o_dram_we    = dram_we_q;
   assign bus.o_dram_addr  = dram_addr_q;
   assign bus.o_dram_wdata = dram_wdata_q;

endmodule

// File: doc/dram_arbiter.md
Name: dram_arbiter

Overview:
Shares the single DRAM port between the GPU memory masters: vertex_fetch (0), shader_core (1) and framebuffer (2).
- Round-robin arbitration with an optional per-master burst lock.
- Separate write enable per request.
- Fixed-latency read return, tagged back to the issuing master.
- Replaces the request-only interconnect path between the masters and the o_dram_* pins of gpu_top.

Parameters:
- NUM_MASTERS, 3, number of requesters.
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width.
- RD_LATENCY, 2, cycles from DRAM read command to valid i_dram_rdata; legal range 1..8.
- MAX_LOCK, 16, maximum locked-burst length (used only with the optional feature).

Ports:
- clk  in  1  clock.
- glbl_rst_n  in  1  reset, asynchronous, active-low.
- i_req  in  NUM_MASTERS  per-master request.
- i_we  in  NUM_MASTERS  per-master write enable (1 = write, 0 = read).
- i_lock  in  NUM_MASTERS  hold grant after this access (burst).
- i_addr  in  NUM_MASTERS x ADDR_WIDTH  per-master address.
- i_wdata  in  NUM_MASTERS x DATA_WIDTH  per-master write data.
- o_gnt  out  NUM_MASTERS  one-hot; request accepted this cycle.
- o_rvalid  out  NUM_MASTERS  one-hot; o_rdata belongs to this master.
- o_rdata  out  DATA_WIDTH  read return data.
- o_dram_req  out  1  DRAM command valid.
- o_dram_we  out  1  DRAM write.
- o_dram_addr  out  ADDR_WIDTH  DRAM address.
- o_dram_wdata  out  DATA_WIDTH  DRAM write data.
- i_dram_rdata  in  DATA_WIDTH  DRAM read data.

Behaviour:
- Reset, on glbl_rst_n low:
  - All outputs 0.
  - rr pointer = 0, state = ARB_IDLE, lock owner cleared.
  - Read tag pipeline cleared. In-flight reads are discarded; no o_rvalid is issued for them after reset.
- Handshake:
  - A master holds i_req, i_we, i_addr and i_wdata stable until it sees o_gnt in the same cycle.
  - o_gnt is combinational from i_req and registered state.
  - At most one grant per cycle; full throughput is 1 access per cycle.
- Arbitration:
  - ARB_IDLE: grant the first requester at or after the rr pointer, wrapping modulo NUM_MASTERS.
  - On a grant to m, the pointer becomes (m+1) mod NUM_MASTERS.
  - If the granted master also has i_lock=1, go to ARB_LOCKED with owner = m.
  - ARB_LOCKED: only the owner can be granted.
  - Leave ARB_LOCKED in the first cycle the owner has i_req=0 or i_lock=0.
  - If the owner still has i_req=1 in that cycle, it gets its last locked grant.
  - Otherwise, arbitration among the other masters happens in that same cycle, per the ARB_IDLE rules.
  - The pointer does not advance while ARB_LOCKED.
- Command timing:
  - Grant in cycle t → o_dram_req=1 in t+1, with o_dram_we, o_dram_addr and o_dram_wdata registered from the granted master.
  - o_dram_req=0 in cycles with no grant; other command outputs hold their last value.
- Read return:
  - Each read command pushes a valid flag and master id into a RD_LATENCY+1 deep shift register.
  - i_dram_rdata is sampled at t+1+RD_LATENCY.
  - o_rdata and o_rvalid[m] are registered at t+2+RD_LATENCY; o_rvalid is high for exactly 1 cycle.
  - Writes produce no response.
- Back-to-back reads from different masters return in issue order, one per cycle.

Optional Feature:
DRAM_ARB_LOCK_TIMEOUT_EN
- Defined: a counter counts locked grants.
  - After MAX_LOCK consecutive grants to the owner, the lock is forcibly released and the state returns to ARB_IDLE.
  - The owner cannot re-lock until one other master has been granted, or until no other master requests for 1 cycle.
- Undefined: the lock is held indefinitely while the owner keeps i_req=1 and i_lock=1; no counter is synthesised.

Decomposition:
- Package gpu_mem_pkg:
  - MID_VERTEX_FETCH=0, MID_SHADER=1, MID_FRAMEBUFFER=2.
  - typedef arb_state_t {ARB_IDLE, ARB_LOCKED}.
  - typedef rd_tag_t {valid, master id of width $clog2(NUM_MASTERS)}.
- Sub-module rr_arbiter: purely combinational, takes request vector and pointer, returns one-hot grant.
- Lock FSM and tag pipeline stay in dram_arbiter.

Test Plan:
- All 3 masters request reads continuously, no lock → grants cycle 0,1,2,0,1,2.
  - With RD_LATENCY=2, o_rvalid for each appears 4 cycles after its grant, with matching data.
- Master 2 writes addr 0x100 data 0xDEADBEEF, granted at t → at t+1: o_dram_req=1, o_dram_we=1, o_dram_addr=0x100, o_dram_wdata=0xDEADBEEF. No o_rvalid follows.
- Master 0 locks a 5-access burst while masters 1 and 2 request → 5 consecutive grants to 0, then master 1, then master 2.
- Owner drops i_lock on its 3rd access while master 1 requests → master 0 granted on that cycle, master 1 granted next cycle.
- glbl_rst_n pulsed low 1 cycle after a read grant → no o_rvalid afterwards; all outputs 0 during reset.
- With DRAM_ARB_LOCK_TIMEOUT_EN and MAX_LOCK=4: master 1 holds the lock with continuous i_req while master 2 requests → exactly 4 grants to master 1, then master 2 granted.
